// File: rtl/apb_regfile_slave.sv
// APB completer with a parameterised 32-bit register bank, programmable wait states,
// a read-only ID register (index 0) and a read-only completed-transfer counter (index 1).
module apb_regfile_slave #(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic [7:0]  PADDR,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic        PREADY,
    output logic [31:0] PRDATA,
    output logic        PSLVERR
);

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   lat_addr;
    logic                lat_write;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W-1:0]   txn_cnt;
    logic [DATA_W-1:0]   rw_regs [2:NUM_REGS-1];

    logic [IDX_W-1:0]    idx_c;
    logic                err_c;
    logic                ready_c;
    logic                commit_wr_c;
    logic [DATA_W-1:0]   reg_rdata_c;

    // Decode always works on the values captured in the setup phase.
    assign idx_c = lat_addr[7:2];
    assign err_c = (lat_addr[1:0] != 2'b00)
                 || ({1'b0, idx_c} >= 7'(NUM_REGS))
                 || (lat_write && (idx_c < 6'd2));

    assign ready_c     = (state == ACCESS) && (cnt == '0);
    assign commit_wr_c = ready_c && PSEL && PENABLE && lat_write && !err_c;

    // Read mux; ID and counter are not part of the storage array.
    always_comb begin
        reg_rdata_c = '0;
        if (idx_c == 6'd0) begin
            reg_rdata_c = ID_VALUE;
        end else if (idx_c == 6'd1) begin
            reg_rdata_c = txn_cnt;
        end else begin
            for (int unsigned i = 2; i < NUM_REGS; i++) begin
                if (idx_c == IDX_W'(i)) begin
                    reg_rdata_c = rw_regs[i];
                end
            end
        end
    end

    // Transfer control: setup capture, wait countdown, completion and abort.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            txn_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        lat_addr  <= PADDR;
                        lat_write <= PWRITE;
                        lat_wdata <= PWDATA;
                        cnt       <= CNT_W'(WAIT_STATES);
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (PENABLE) begin
                        state <= IDLE;
                        if (!err_c) begin
                            txn_cnt <= txn_cnt + DATA_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read/write storage for indices 2..NUM_REGS-1.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            for (int unsigned i = 2; i < NUM_REGS; i++) begin
                rw_regs[i] <= '0;
            end
        end else if (commit_wr_c) begin
            for (int unsigned i = 2; i < NUM_REGS; i++) begin
                if (idx_c == IDX_W'(i)) begin
                    rw_regs[i] <= lat_wdata;
                end
            end
        end
    end

    // Response is a function of registered state only, so reset clears it at once.
    assign PREADY  = ready_c;
    assign PSLVERR = ready_c && err_c;
    assign PRDATA  = (ready_c && !lat_write && !err_c) ? reg_rdata_c : '0;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: three builds (WAIT_STATES = 1, 0, 3) on one clock,
// a vector table of single transfers plus abort, idle-PENABLE and mid-transfer reset sequences.
module tb_apb_regfile_slave;

    logic        clk;
    logic        preset;
    logic [2:0]  psel;
    logic [2:0]  penable;
    logic [2:0]  pwrite;
    logic [7:0]  paddr  [3];
    logic [31:0] pwdata [3];
    logic [2:0]  pready;
    logic [2:0]  pslverr;
    logic [31:0] prdata [3];

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] ID = 32'hA9B0_0001;

    apb_regfile_slave #(.NUM_REGS(16), .WAIT_STATES(1)) dut0 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PADDR(paddr[0]), .PWRITE(pwrite[0]), .PWDATA(pwdata[0]),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

    apb_regfile_slave #(.NUM_REGS(16), .WAIT_STATES(0)) dut1 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PADDR(paddr[1]), .PWRITE(pwrite[1]), .PWDATA(pwdata[1]),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

    apb_regfile_slave #(.NUM_REGS(16), .WAIT_STATES(3)) dut2 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable[2]),
        .PADDR(paddr[2]), .PWRITE(pwrite[2]), .PWDATA(pwdata[2]),
        .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          d;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_waits;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // One full APB transfer; PADDR/PWDATA are scrambled during ACCESS to prove they are ignored.
    task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int waits);
        bit done;
        @(negedge clk);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
        @(negedge clk);
        penable[d] = 1'b1; paddr[d] = ~a; pwdata[d] = ~wd;
        waits = 0; done = 1'b0; rd = 'x; err = 1'bx;
        for (int n = 0; n < 40 && !done; n++) begin
            if (pready[d]) begin
                rd = prdata[d]; err = pslverr[d]; done = 1'b1;
            end else begin
                waits++;
                @(negedge clk);
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL timeout: dut%0d addr 0x%02h no PREADY within 40 cycles", d, a);
        end
        @(negedge clk);
        psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] rd;
        logic        err;
        int          waits;
        xfer(v.d, v.wr, v.addr, v.wdata, rd, err, waits);
        chk({tag, " prdata"}, rd, v.exp_rdata);
        chk({tag, " pslverr"}, 32'(err), 32'(v.exp_err));
        chk({tag, " waits"}, 32'(waits), 32'(v.exp_waits));
    endtask

    vec_t vecs [$];
    logic [31:0] rd;
    logic        err;
    int          waits;

    initial begin
        // dut0, WAIT_STATES=1: ID, RW, TXN counter, error decode
        vecs.push_back('{0, 1'b0, 8'h00, 32'h0,          ID,           1'b0, 1});
        vecs.push_back('{0, 1'b1, 8'h08, 32'hDEAD_BEEF, 32'h0,        1'b0, 1});
        vecs.push_back('{0, 1'b0, 8'h08, 32'h0,          32'hDEAD_BEEF, 1'b0, 1});
        vecs.push_back('{0, 1'b0, 8'h04, 32'h0,          32'd3,        1'b0, 1});
        vecs.push_back('{0, 1'b0, 8'h09, 32'h0,          32'h0,        1'b1, 1});
        vecs.push_back('{0, 1'b1, 8'h09, 32'h5555_5555, 32'h0,        1'b1, 1});
        vecs.push_back('{0, 1'b0, 8'h40, 32'h0,          32'h0,        1'b1, 1});
        vecs.push_back('{0, 1'b1, 8'h40, 32'h6666_6666, 32'h0,        1'b1, 1});
        vecs.push_back('{0, 1'b1, 8'h00, 32'h7777_7777, 32'h0,        1'b1, 1});
        vecs.push_back('{0, 1'b1, 8'h04, 32'h8888_8888, 32'h0,        1'b1, 1});
        vecs.push_back('{0, 1'b0, 8'h00, 32'h0,          ID,           1'b0, 1});
        vecs.push_back('{0, 1'b0, 8'h04, 32'h0,          32'd5,        1'b0, 1});
        vecs.push_back('{0, 1'b0, 8'h3C, 32'h0,          32'h0,        1'b0, 1});
        vecs.push_back('{0, 1'b1, 8'h3C, 32'hA5A5_5A5A, 32'h0,        1'b0, 1});
        vecs.push_back('{0, 1'b0, 8'h3C, 32'h0,          32'hA5A5_5A5A, 1'b0, 1});
        vecs.push_back('{0, 1'b0, 8'h08, 32'h0,          32'hDEAD_BEEF, 1'b0, 1});
        vecs.push_back('{0, 1'b0, 8'h04, 32'h0,          32'd10,       1'b0, 1});
        // dut1, WAIT_STATES=0
        vecs.push_back('{1, 1'b1, 8'h0C, 32'h1234_5678, 32'h0,        1'b0, 0});
        vecs.push_back('{1, 1'b0, 8'h0C, 32'h0,          32'h1234_5678, 1'b0, 0});
        vecs.push_back('{1, 1'b0, 8'h04, 32'h0,          32'd2,        1'b0, 0});
        // dut2, WAIT_STATES=3
        vecs.push_back('{2, 1'b1, 8'h0C, 32'h1234_5678, 32'h0,        1'b0, 3});
        vecs.push_back('{2, 1'b0, 8'h0C, 32'h0,          32'h1234_5678, 1'b0, 3});
        vecs.push_back('{2, 1'b0, 8'h04, 32'h0,          32'd2,        1'b0, 3});

        preset = 1'b0;
        psel = '0; penable = '0; pwrite = '0;
        for (int i = 0; i < 3; i++) begin
            paddr[i] = '0; pwdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset dut%0d pready", i), 32'(pready[i]), 32'h0);
            chk($sformatf("reset dut%0d prdata", i), prdata[i], 32'h0);
            chk($sformatf("reset dut%0d pslverr", i), 32'(pslverr[i]), 32'h0);
        end
        preset = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort on dut2: good write first, then a write dropped after one access cycle.
        xfer(2, 1'b1, 8'h10, 32'h1111_1111, rd, err, waits);
        chk("abort pre-write err", 32'(err), 32'h0);
        @(negedge clk);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'h10; pwdata[2] = 32'hBAD0_BAD0;
        @(negedge clk);
        penable[2] = 1'b1;
        chk("abort access1 pready", 32'(pready[2]), 32'h0);
        @(negedge clk);
        psel[2] = 1'b0; penable[2] = 1'b0;
        chk("abort access2 pready", 32'(pready[2]), 32'h0);
        @(negedge clk);
        chk("abort after pready", 32'(pready[2]), 32'h0);
        pwrite[2] = 1'b0;
        xfer(2, 1'b0, 8'h10, 32'h0, rd, err, waits);
        chk("abort reg4 kept", rd, 32'h1111_1111);
        chk("abort next waits", 32'(waits), 32'd3);
        xfer(2, 1'b0, 8'h04, 32'h0, rd, err, waits);
        chk("abort txn", rd, 32'd5);

        // PENABLE without setup on dut0 must be ignored.
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 8'h08;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("no-setup pready %0d", i), 32'(pready[0]), 32'h0);
        end
        psel[0] = 1'b0; penable[0] = 1'b0;
        xfer(0, 1'b0, 8'h04, 32'h0, rd, err, waits);
        chk("no-setup txn", rd, 32'd11);

        // Asynchronous reset in the middle of a zero-wait write on dut1.
        @(negedge clk);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h14; pwdata[1] = 32'hCAFE_F00D;
        @(negedge clk);
        penable[1] = 1'b1;
        chk("midrst pready before", 32'(pready[1]), 32'h1);
        #2 preset = 1'b0;
        #1;
        chk("midrst pready", 32'(pready[1]), 32'h0);
        chk("midrst pslverr", 32'(pslverr[1]), 32'h0);
        chk("midrst prdata", prdata[1], 32'h0);
        @(negedge clk);
        psel[1] = 1'b0; penable[1] = 1'b0; pwrite[1] = 1'b0;
        @(negedge clk);
        preset = 1'b1;
        xfer(1, 1'b0, 8'h04, 32'h0, rd, err, waits);
        chk("midrst txn", rd, 32'h0);
        xfer(1, 1'b0, 8'h14, 32'h0, rd, err, waits);
        chk("midrst reg5", rd, 32'h0);
        chk("midrst reg5 err", 32'(err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
